frame_transfer_mblk_stats_sink: RTL
===================================

Name: frame_transfer_mblk_stats_sink

Overview:
- Receiving end of the frame-transfer stream: consumes RGB24 pixels delivered macroblock by macroblock.
- For each complete macroblock, computes the per-channel mean colour and checks framing. Flags length and type violations.
- Sits downstream of the camera sensor driver as the first consumer, feeding statistics to auto-exposure/white-balance logic.
- Stream has no backpressure: sink accepts every active cycle.

Parameters:
- CNT_W, 16, width of completed-macroblock and error counters.

Ports:
- ul1Clock  in  1  sole clock; all logic rising-edge.
- ul1Reset_n  in  1  synchronous, active-low reset.
- ul1Active  in  1  pixel qualifier; ul24Rgb24Data valid when high.
- ul2MacroBlockType  in  2  0=16x16 (N=256), 1=8x8 (N=64), 2=4x4 (N=16), 3=reserved.
- ul24Rgb24Data  in  24  pixel; [23:16]=R, [15:8]=G, [7:0]=B.
- ul1MacroBlockEnd  in  1  high with ul1Active on last pixel of macroblock.
- ul1Clear  in  1  synchronous clear of both counters.
- ul24MeanRgb  out  24  mean R/G/B of last good macroblock, same packing.
- ul1MeanValid  out  1  one-cycle pulse when ul24MeanRgb updates.
- ul1ErrLength  out  1  one-cycle pulse on length violation.
- ul1ErrType  out  1  one-cycle pulse on reserved/changed type.
- ulMblkCount  out  CNT_W  good macroblocks completed, wraps.
- ulErrCount  out  CNT_W  total errors, saturates at all-ones.

Behaviour:
- Reset (ul1Reset_n low at clock edge): state=IDLE; pixel count, sums, ul24MeanRgb, both counters = 0; all pulses low. Reset mid-macroblock discards it silently; no error is flagged.
- Cycles with ul1Active=0 are ignored entirely; ul1MacroBlockEnd is ignored while inactive.
- States:
  - IDLE: waiting for the first pixel.
  - ACCUM: accumulating a block.
  - DISCARD: dropping the rest of a bad block.
- IDLE, active pixel:
  - type=3: ErrType pulse; go to DISCARD, or stay IDLE if End is also high.
  - otherwise: latch type → N. Sums = pixel channels, count=1. Go to ACCUM.
  - If End is also high on that pixel: N=1 is impossible, so this is an early end. ErrLength pulse, return to IDLE.
- ACCUM, active pixel:
  - Type differs from the latched type: ErrType pulse. Go to DISCARD, or to IDLE if End is high.
  - Else add the pixel to three 16-bit sums (max 255*256=65280, no overflow) and increment count.
  - End high and count+1==N: good block, return to IDLE.
  - End high and count+1<N: ErrLength pulse, IDLE.
  - End low and count+1==N: ErrLength pulse (missing end), DISCARD.
- DISCARD: drop active pixels; on an active pixel with End high, return to IDLE. No further error pulses.
- Good block: on the next cycle (latency 1 after the End pixel), ul24MeanRgb = {sumR>>s, sumG>>s, sumB>>s}, where s=8/6/4 for types 0/1/2 (truncating). ul1MeanValid pulses high for exactly that cycle. ulMblkCount increments, wrapping from all-ones to 0.
- Error pulses are registered: high the cycle after the offending pixel, for one cycle.
- ulErrCount increments once per pulsed error (ErrLength or ErrType; never both for one pixel, ErrType takes priority). Saturates at all-ones.
- ul24MeanRgb holds its value between good blocks.
- ul1Clear: counters → 0 on the next edge. If a count event coincides with Clear, Clear wins. Clear does not affect state, sums or mean.
- A new block may start on the cycle immediately after an End pixel (back-to-back), with no bubble required.

Test Plan:
- Reset, then one 16x16 block with all pixels 0x804020 and End on pixel 256 → next cycle ul24MeanRgb=0x804020, ul1MeanValid=1 for 1 cycle, ulMblkCount=1, no errors.
- 4x4 block with pixels 0..15 on all channels (value p → 0xpppppp), End on the 16th, with ul1Active toggled low every other cycle → mean 0x070707 (120>>4=7); gaps do not affect the result.
- 8x8 block with End on pixel 40 → ErrLength pulse, ulErrCount=1, ulMblkCount unchanged. The immediately following valid 8x8 block of 0xFFFFFF gives mean 0xFFFFFF.
- 4x4 block without End on the 16th pixel, then 3 more pixels with End on the last → one ErrLength at pixel 16, DISCARD until End, ulErrCount=1. The next block is accepted.
- Type=3 first pixel → ErrType pulse, pixels dropped until End. A type change from 0 to 1 at pixel 10 → ErrType. ulErrCount=2.
- Preload ulMblkCount=0xFFFF via 65535 4x4 blocks (or force), one more good block → wraps to 0. Assert Clear together with a block completion → both counters 0. Assert reset mid-block → no MeanValid, block lost.

Source files
------------

// File: rtl/frame_transfer_mblk_stats_sink.sv
// Macroblock statistics sink: checks framing of an RGB24 macroblock stream and
// reports the per-channel mean of every correctly framed block.
module frame_transfer_mblk_stats_sink #(
  parameter int CNT_W = 16
) (
  input  logic             ul1Clock,
  input  logic             ul1Reset_n,
  input  logic             ul1Active,
  input  logic [1:0]       ul2MacroBlockType,
  input  logic [23:0]      ul24Rgb24Data,
  input  logic             ul1MacroBlockEnd,
  input  logic             ul1Clear,
  output logic [23:0]      ul24MeanRgb,
  output logic             ul1MeanValid,
  output logic             ul1ErrLength,
  output logic             ul1ErrType,
  output logic [CNT_W-1:0] ulMblkCount,
  output logic [CNT_W-1:0] ulErrCount
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [15:0]      sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
  logic [23:0]      mean_q;
  logic             mean_valid_q, err_len_q, err_type_q;
  logic [CNT_W-1:0] mblk_cnt_q, err_cnt_q;

  logic             good_s, err_len_s, err_type_s;
  logic [8:0]       cnt_inc_s;
  logic [15:0]      add_r_s, add_g_s, add_b_s;

  function automatic logic [8:0] blk_len(input logic [1:0] t);
    case (t)
      2'd0:    blk_len = 9'd256;
      2'd1:    blk_len = 9'd64;
      2'd2:    blk_len = 9'd16;
      default: blk_len = 9'd0;
    endcase
  endfunction

  // Dividing by the pixel count is a shift; the sum never exceeds 255*N so 8 bits remain.
  function automatic logic [7:0] mean_of(input logic [15:0] sum, input logic [1:0] t);
    logic [15:0] sh;
    case (t)
      2'd0:    sh = sum >> 8;
      2'd1:    sh = sum >> 6;
      2'd2:    sh = sum >> 4;
      default: sh = 16'd0;
    endcase
    mean_of = sh[7:0];
  endfunction

  assign cnt_inc_s = cnt_q + 9'd1;
  assign add_r_s   = sum_r_q + {8'd0, ul24Rgb24Data[23:16]};
  assign add_g_s   = sum_g_q + {8'd0, ul24Rgb24Data[15:8]};
  assign add_b_s   = sum_b_q + {8'd0, ul24Rgb24Data[7:0]};

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    cnt_d      = cnt_q;
    sum_r_d    = sum_r_q;
    sum_g_d    = sum_g_q;
    sum_b_d    = sum_b_q;
    good_s     = 1'b0;
    err_len_s  = 1'b0;
    err_type_s = 1'b0;
    if (ul1Active) begin
      case (state_q)
        S_IDLE: begin
          if (ul2MacroBlockType == 2'd3) begin
            err_type_s = 1'b1;
            state_d    = ul1MacroBlockEnd ? S_IDLE : S_DISCARD;
          end else begin
            type_d  = ul2MacroBlockType;
            cnt_d   = 9'd1;
            sum_r_d = {8'd0, ul24Rgb24Data[23:16]};
            sum_g_d = {8'd0, ul24Rgb24Data[15:8]};
            sum_b_d = {8'd0, ul24Rgb24Data[7:0]};
            // No block is one pixel long, so End on the first pixel is always early.
            if (ul1MacroBlockEnd) begin
              err_len_s = 1'b1;
              state_d   = S_IDLE;
            end else begin
              state_d   = S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (ul2MacroBlockType != type_q) begin
            err_type_s = 1'b1;
            state_d    = ul1MacroBlockEnd ? S_IDLE : S_DISCARD;
          end else begin
            sum_r_d = add_r_s;
            sum_g_d = add_g_s;
            sum_b_d = add_b_s;
            cnt_d   = cnt_inc_s;
            if (ul1MacroBlockEnd) begin
              state_d = S_IDLE;
              if (cnt_inc_s == blk_len(type_q)) begin
                good_s    = 1'b1;
              end else begin
                err_len_s = 1'b1;
              end
            end else if (cnt_inc_s == blk_len(type_q)) begin
              err_len_s = 1'b1;
              state_d   = S_DISCARD;
            end else begin
              state_d   = S_ACCUM;
            end
          end
        end
        S_DISCARD: begin
          state_d = ul1MacroBlockEnd ? S_IDLE : S_DISCARD;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge ul1Clock) begin
    if (!ul1Reset_n) begin
      state_q      <= S_IDLE;
      type_q       <= 2'd0;
      cnt_q        <= 9'd0;
      sum_r_q      <= 16'd0;
      sum_g_q      <= 16'd0;
      sum_b_q      <= 16'd0;
      mean_q       <= 24'd0;
      mean_valid_q <= 1'b0;
      err_len_q    <= 1'b0;
      err_type_q   <= 1'b0;
      mblk_cnt_q   <= {CNT_W{1'b0}};
      err_cnt_q    <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      cnt_q        <= cnt_d;
      sum_r_q      <= sum_r_d;
      sum_g_q      <= sum_g_d;
      sum_b_q      <= sum_b_d;
      mean_valid_q <= good_s;
      err_len_q    <= err_len_s;
      err_type_q   <= err_type_s;
      if (good_s) begin
        mean_q <= {mean_of(sum_r_d, type_q), mean_of(sum_g_d, type_q), mean_of(sum_b_d, type_q)};
      end else begin
        mean_q <= mean_q;
      end
      // Clear takes precedence over a coincident count event.
      if (ul1Clear) begin
        mblk_cnt_q <= {CNT_W{1'b0}};
      end else if (good_s) begin
        mblk_cnt_q <= mblk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        mblk_cnt_q <= mblk_cnt_q;
      end
      if (ul1Clear) begin
        err_cnt_q <= {CNT_W{1'b0}};
      end else if ((err_len_s || err_type_s) && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        err_cnt_q <= err_cnt_q;
      end
    end
  end

  assign ul24MeanRgb  = mean_q;
  assign ul1MeanValid = mean_valid_q;
  assign ul1ErrLength = err_len_q;
  assign ul1ErrType   = err_type_q;
  assign ulMblkCount  = mblk_cnt_q;
  assign ulErrCount   = err_cnt_q;

endmodule
